ap_ctrl_sequencer: RTL and testbench
====================================

AP_CTRL_SEQUENCER -- requirements
Module: ap_ctrl_sequencer

Interface
REQ-001 SHALL have parameter NUM_TRANS, default 16, number of transactions to issue (0 allowed).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256, max cycles a transaction may wait for ap_ready or ap_done.
REQ-003 SHALL have parameter SEED, default 16'hACE1, non-zero LFSR seed.
REQ-004 SHALL have ports, clock and reset first:
 clock  in  1  sole clock, all state on rising edge
 reset  in  1  asynchronous, active-low reset (asserted at 0)
 enable  in  1  permits issuing new transactions
 ap_start  out  1  ap_ctrl_hs start to DUT
 ap_ready  in  1  DUT accepted inputs
 ap_done  in  1  DUT result valid
 op_a  out  8  signed operand A
 op_b  out  8  signed operand B
 dut_sum  in  9  DUT result, two's complement
 finish  out  1  run complete; feeds dataflow monitor finish
 pass_count  out  16  matching results
 fail_count  out  16  mismatching results
 timeout_err  out  1  sticky, a wait exceeded TIMEOUT_CYC
 protocol_err  out  1  sticky, ap_done with nothing outstanding

Function
REQ-005 SHALL implement FSM states IDLE, START, WAIT_DONE, DONE; at most one transaction outstanding.
REQ-006 IDLE: if issued==NUM_TRANS -> DONE; else if enable -> START next cycle.
REQ-007 START: ap_start=1, op_a/op_b held stable until ap_start&ap_ready.
REQ-008 On ap_start&ap_ready: capture expected = sext9(op_a)+sext9(op_b) (9-bit wrap), increment issued, advance LFSR once; -> WAIT_DONE.
REQ-009 ap_ready and ap_done in the same START cycle (zero-latency DUT) SHALL be compared immediately against the expected value of that same transaction; FSM -> IDLE.
REQ-010 WAIT_DONE: ap_start=0; on ap_done compare dut_sum to expected, increment pass_count or fail_count (saturate at 16'hFFFF), -> IDLE.
REQ-011 Deasserting enable mid-transaction SHALL NOT abort it; FSM parks in IDLE after completion.
REQ-012 Wait counter SHALL clear on entering START and WAIT_DONE and count cycles in them; reaching TIMEOUT_CYC sets timeout_err, drops ap_start, -> DONE.
REQ-013 ap_done in IDLE or DONE SHALL set protocol_err and SHALL NOT change counters or state.
REQ-014 DONE: finish=1 held until reset; ap_start=0; terminal state.
REQ-015 op_a=lfsr[15:8], op_b=lfsr[7:0]; LFSR 16-bit Fibonacci, taps 16,14,13,11.
REQ-016 NUM_TRANS=0 SHALL reach DONE one cycle after reset release, no ap_start pulse.

Reset
REQ-017 reset=0 SHALL immediately force: state IDLE, ap_start 0, finish 0, pass/fail_count 0, timeout_err 0, protocol_err 0, LFSR=SEED (op_a 8'hAC, op_b 8'hE1), issued 0, wait counter 0.
REQ-018 Reset asserted mid-transaction SHALL discard the outstanding transaction; no count update.

Structure
REQ-019 Package ap_seq_pkg SHALL hold the FSM state enum, LFSR tap mask, default SEED and TIMEOUT_CYC constants.
REQ-020 LFSR SHALL be sub-module ap_seq_lfsr (ports clock, reset, advance, state[15:0]); all else in ap_ctrl_sequencer.

Verification
REQ-021 Zero-latency DUT model (ready=done=ap_start, correct sum), NUM_TRANS=4 -> pass_count=4, fail_count=0, finish rises within one cycle of the 4th ap_done.
REQ-022 Latency-3 DUT: op_a=8'hAC, op_b=8'hE1 stable until ap_ready; dut_sum=9'h18D -> pass_count=1.
REQ-023 DUT corrupts dut_sum on transaction 2 of 4 -> pass_count=3, fail_count=1, finish=1.
REQ-024 DUT never asserts ap_ready, TIMEOUT_CYC=256 -> timeout_err=1, ap_start=0, finish=1 at wait-counter value 256, counts 0.
REQ-025 ap_done pulse while IDLE with enable=0 -> protocol_err=1, counts unchanged, state IDLE.
REQ-026 reset=0 during WAIT_DONE -> all outputs at REQ-017 values before next clock edge; re-run after release reproduces op_a=8'hAC, op_b=8'hE1.

Source files
------------

// File: rtl/ap_seq_pkg.sv
// ---------------------------------------------------------------------------
// ap_seq_pkg
// Shared definitions for the ap_ctrl_hs test sequencer:
//   - ap_seq_state_e : sequencer FSM states
//   - LFSR_TAPS      : feedback mask for the 16-bit Fibonacci LFSR
//                      (taps 16,14,13,11 -> state bits 15,13,12,10)
//   - DEFAULT_SEED / DEFAULT_TIMEOUT_CYC : parameter defaults
//   - sum9()         : expected DUT result, 9-bit two's complement sum
//   - sat_inc16()    : saturating result-counter increment
// ---------------------------------------------------------------------------
package ap_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DONE      = 2'd3
  } ap_seq_state_e;

  localparam logic [15:0] LFSR_TAPS           = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED        = 16'hACE1;
  localparam int          DEFAULT_TIMEOUT_CYC = 256;

  // Sign-extend both operands to 9 bits and add; the 9-bit result cannot
  // overflow for 8-bit signed inputs, so plain wrap is exact.
  function automatic logic [8:0] sum9(input logic [7:0] a, input logic [7:0] b);
    return {a[7], a} + {b[7], b};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ap_seq_lfsr.sv
// ---------------------------------------------------------------------------
// ap_seq_lfsr
// 16-bit Fibonacci LFSR, shifts left and inserts the XOR of the tapped bits
// at bit 0. Steps once per cycle that advance is high.
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset, loads SEED
//   advance : step the register this cycle
//   state   : current LFSR contents
// ---------------------------------------------------------------------------
module ap_seq_lfsr
  import ap_seq_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ap_ctrl_sequencer
// Issues NUM_TRANS add transactions to a DUT over an ap_ctrl_hs handshake,
// using LFSR-generated signed operands, checks each 9-bit result and keeps
// pass/fail tallies. Raises finish once all transactions are done or a wait
// times out.
//
// Handshake: ap_start is held high with op_a/op_b stable until a cycle in
// which ap_ready is also high; that cycle transfers the operands. ap_done
// marks dut_sum valid for the single outstanding transaction and may arrive
// in the transfer cycle itself (zero-latency DUT) or any later cycle.
//
// Ports:
//   clock, reset          : clock, async active-low reset
//   enable                : allows new transactions to be issued
//   ap_start/ap_ready     : start handshake towards the DUT
//   ap_done, dut_sum      : DUT result return
//   op_a, op_b            : signed operands (LFSR high/low byte)
//   finish                : run complete (sticky until reset)
//   pass_count/fail_count : saturating result tallies
//   timeout_err           : sticky, a wait exceeded TIMEOUT_CYC
//   protocol_err          : sticky, ap_done with nothing outstanding
//   state_dbg             : current FSM state
// ---------------------------------------------------------------------------
module ap_ctrl_sequencer
  import ap_seq_pkg::*;
#(
  parameter int          NUM_TRANS   = 16,
  parameter int          TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter logic [15:0] SEED        = DEFAULT_SEED
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  output logic          ap_start,
  input  logic          ap_ready,
  input  logic          ap_done,
  output logic [7:0]    op_a,
  output logic [7:0]    op_b,
  input  logic [8:0]    dut_sum,
  output logic          finish,
  output logic [15:0]   pass_count,
  output logic [15:0]   fail_count,
  output logic          timeout_err,
  output logic          protocol_err,
  output ap_seq_state_e state_dbg
);

  localparam int          WCW          = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);
  localparam logic [15:0] ISSUE_TARGET = 16'(NUM_TRANS);

  ap_seq_state_e  fsm_state;
  logic [15:0]    issued;
  logic [WCW-1:0] wait_cnt;
  logic [8:0]     exp_sum;
  logic [15:0]    lfsr_state;
  logic           lfsr_advance;
  logic [8:0]     cmp_ref;
  logic           result_match;

  assign state_dbg = fsm_state;
  assign op_a      = lfsr_state[15:8];
  assign op_b      = lfsr_state[7:0];

  // Operands move on only once the DUT has taken them.
  assign lfsr_advance = (fsm_state == ST_START) && ap_start && ap_ready;

  ap_seq_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (lfsr_advance),
    .state   (lfsr_state)
  );

  // A zero-latency result arrives before exp_sum is written, so it is
  // checked against the operands still on op_a/op_b.
  always_comb begin
    cmp_ref = exp_sum;
    if (fsm_state == ST_START) begin
      cmp_ref = sum9(op_a, op_b);
    end
  end

  assign result_match = (dut_sum == cmp_ref);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_state    <= ST_IDLE;
      ap_start     <= 1'b0;
      finish       <= 1'b0;
      pass_count   <= '0;
      fail_count   <= '0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
      issued       <= '0;
      wait_cnt     <= '0;
      exp_sum      <= '0;
    end else begin
      case (fsm_state)
        ST_IDLE: begin
          if (ap_done) begin
            protocol_err <= 1'b1;
          end
          if (issued == ISSUE_TARGET) begin
            fsm_state <= ST_DONE;
            finish    <= 1'b1;
          end else if (enable) begin
            fsm_state <= ST_START;
            ap_start  <= 1'b1;
            wait_cnt  <= '0;
          end
        end

        ST_START: begin
          if (ap_ready) begin
            issued   <= issued + 16'd1;
            ap_start <= 1'b0;
            wait_cnt <= '0;
            if (ap_done) begin
              if (result_match) pass_count <= sat_inc16(pass_count);
              else              fail_count <= sat_inc16(fail_count);
              fsm_state <= ST_IDLE;
            end else begin
              exp_sum   <= sum9(op_a, op_b);
              fsm_state <= ST_WAIT_DONE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt    <= wait_cnt + WCW'(1);
            timeout_err <= 1'b1;
            ap_start    <= 1'b0;
            finish      <= 1'b1;
            fsm_state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        ST_WAIT_DONE: begin
          if (ap_done) begin
            if (result_match) pass_count <= sat_inc16(pass_count);
            else              fail_count <= sat_inc16(fail_count);
            fsm_state <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt    <= wait_cnt + WCW'(1);
            timeout_err <= 1'b1;
            finish      <= 1'b1;
            fsm_state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        ST_DONE: begin
          if (ap_done) begin
            protocol_err <= 1'b1;
          end
          ap_start <= 1'b0;
          finish   <= 1'b1;
        end

        default: begin
          fsm_state <= ST_IDLE;
          ap_start  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_sequencer
// Directed and randomized scenarios for ap_ctrl_sequencer. A behavioural
// model (LFSR stepped with integer arithmetic, integer signed sums, expected
// pass/fail tallies) provides every expected value.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_sequencer;
  import ap_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          enable;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [8:0]    dut_sum;
  logic          finish;
  logic [15:0]   pass_count;
  logic [15:0]   fail_count;
  logic          timeout_err;
  logic          protocol_err;
  ap_seq_state_e state_dbg;

  // second instance, NUM_TRANS = 0
  logic          z_ap_start;
  logic [7:0]    z_op_a;
  logic [7:0]    z_op_b;
  logic          z_finish;
  logic [15:0]   z_pass;
  logic [15:0]   z_fail;
  logic          z_terr;
  logic          z_perr;
  ap_seq_state_e z_state;
  logic          z_started = 1'b0;

  ap_ctrl_sequencer #(.NUM_TRANS(4), .TIMEOUT_CYC(256), .SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .op_a(op_a), .op_b(op_b), .dut_sum(dut_sum), .finish(finish),
    .pass_count(pass_count), .fail_count(fail_count),
    .timeout_err(timeout_err), .protocol_err(protocol_err),
    .state_dbg(state_dbg)
  );

  ap_ctrl_sequencer #(.NUM_TRANS(0), .TIMEOUT_CYC(256), .SEED(16'hACE1)) dut0 (
    .clock(clock), .reset(reset), .enable(1'b1),
    .ap_start(z_ap_start), .ap_ready(1'b0), .ap_done(1'b0),
    .op_a(z_op_a), .op_b(z_op_b), .dut_sum(9'd0), .finish(z_finish),
    .pass_count(z_pass), .fail_count(z_fail),
    .timeout_err(z_terr), .protocol_err(z_perr),
    .state_dbg(z_state)
  );

  always @(posedge clock) if (reset && z_ap_start) z_started <= 1'b1;

  // ---------------- scoreboard / model ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_lfsr;
  int          exp_pass;
  int          exp_fail;
  logic [8:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] l);
    int unsigned v;
    int unsigned fb;
    v  = l;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    v  = ((v << 1) | fb) & 32'hFFFF;
    return v[15:0];
  endfunction

  function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    logic [31:0] t;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    t  = sa + sb;
    return t[8:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset    = 1'b0;
    enable   = 1'b0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    dut_sum  = '0;
    repeat (2) @(negedge clock);
    reset      = 1'b1;
    model_lfsr = 16'hACE1;
    exp_pass   = 0;
    exp_fail   = 0;
    exp_q.delete();
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      if (ap_start) break;
      @(negedge clock);
    end
    chk("start_seen", 32'(ap_start), 32'd1);
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 10; i++) begin
      if (finish) break;
      @(negedge clock);
    end
    chk("finish", 32'(finish), 32'd1);
  endtask

  // One transaction: ready after rlat cycles, done dlat cycles after the
  // transfer (dlat==0 -> same cycle). corrupt flips the result sign bit.
  task automatic serve_txn(input int rlat, input int dlat, input bit corrupt, input bit drop);
    logic [7:0] a0;
    logic [7:0] b0;
    logic [8:0] s;
    wait_start();
    chk("op_a", 32'(op_a), 32'(model_lfsr[15:8]));
    chk("op_b", 32'(op_b), 32'(model_lfsr[7:0]));
    a0 = op_a;
    b0 = op_b;
    repeat (rlat) @(negedge clock);
    chk("hold", 32'({ap_start, op_a, op_b}), 32'({1'b1, a0, b0}));
    exp_q.push_back(model_sum(model_lfsr[15:8], model_lfsr[7:0]));
    s = exp_q.pop_front();
    if (corrupt) s = s ^ 9'h100;
    ap_ready = 1'b1;
    if (drop) enable = 1'b0;
    if (dlat == 0) begin
      ap_done = 1'b1;
      dut_sum = s;
    end
    @(negedge clock);
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (dlat > 0) begin
      repeat (dlat - 1) @(negedge clock);
      chk("start_low_wait", 32'(ap_start), 32'd0);
      ap_done = 1'b1;
      dut_sum = s;
      @(negedge clock);
      ap_done = 1'b0;
    end
    model_lfsr = model_step(model_lfsr);
    if (corrupt) exp_fail++;
    else         exp_pass++;
    chk("pass_count", 32'(pass_count), 32'(exp_pass));
    chk("fail_count", 32'(fail_count), 32'(exp_fail));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    reset    = 1'b0;
    enable   = 1'b0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    dut_sum  = '0;
    repeat (2) @(negedge clock);

    // reset values
    chk("rst_ap_start", 32'(ap_start), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'hAC);
    chk("rst_op_b", 32'(op_b), 32'hE1);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("z_rst_finish", 32'(z_finish), 32'd0);

    reset      = 1'b1;
    model_lfsr = 16'hACE1;
    exp_pass   = 0;
    exp_fail   = 0;
    @(negedge clock);
    chk("z_finish_1cyc", 32'(z_finish), 32'd1);
    chk("z_state_done", 32'(z_state), 32'(ST_DONE));
    chk("idle_no_enable", 32'(state_dbg), 32'(ST_IDLE));

    // zero-latency DUT, 4 transactions
    enable = 1'b1;
    for (int i = 0; i < 4; i++) serve_txn(0, 0, 1'b0, 1'b0);
    chk("zl_finish_early", 32'(finish), 32'd0);
    @(negedge clock);
    chk("zl_finish", 32'(finish), 32'd1);
    chk("zl_pass", 32'(pass_count), 32'd4);
    chk("zl_fail", 32'(fail_count), 32'd0);

    // ap_done while DONE
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    @(negedge clock);
    chk("done_perr", 32'(protocol_err), 32'd1);
    chk("done_pass_kept", 32'(pass_count), 32'd4);
    chk("done_state", 32'(state_dbg), 32'(ST_DONE));

    // latency-3 DUT, first result literal; corrupt transaction 2
    do_reset();
    enable = 1'b1;
    wait_start();
    chk("l3_op_a", 32'(op_a), 32'hAC);
    chk("l3_op_b", 32'(op_b), 32'hE1);
    repeat (3) @(negedge clock);
    chk("l3_hold", 32'({ap_start, op_a, op_b}), 32'h1ACE1);
    ap_ready = 1'b1;
    @(negedge clock);
    ap_ready = 1'b0;
    repeat (2) @(negedge clock);
    ap_done = 1'b1;
    dut_sum = 9'h18D;
    @(negedge clock);
    ap_done = 1'b0;
    chk("l3_pass1", 32'(pass_count), 32'd1);
    model_lfsr = model_step(model_lfsr);
    exp_pass   = 1;
    serve_txn(3, 3, 1'b1, 1'b0);
    serve_txn(3, 3, 1'b0, 1'b0);
    serve_txn(3, 3, 1'b0, 1'b0);
    wait_finish();
    chk("cor_pass", 32'(pass_count), 32'd3);
    chk("cor_fail", 32'(fail_count), 32'd1);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      do_reset();
      enable = 1'b1;
      for (int t = 0; t < 4; t++) begin
        bit drop;
        drop = (t < 3) && ($urandom_range(0, 3) == 0);
        serve_txn($urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 3) == 0, drop);
        if (drop) begin
          repeat (3) @(negedge clock);
          chk("park_state", 32'(state_dbg), 32'(ST_IDLE));
          chk("park_start", 32'(ap_start), 32'd0);
          enable = 1'b1;
        end
      end
      wait_finish();
      chk("rnd_pass", 32'(pass_count), 32'(exp_pass));
      chk("rnd_fail", 32'(fail_count), 32'(exp_fail));
      chk("rnd_terr", 32'(timeout_err), 32'd0);
      chk("rnd_perr", 32'(protocol_err), 32'd0);
    end

    // ap_done while IDLE with enable low
    do_reset();
    @(negedge clock);
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    @(negedge clock);
    chk("idle_perr", 32'(protocol_err), 32'd1);
    chk("idle_pass", 32'(pass_count), 32'd0);
    chk("idle_fail", 32'(fail_count), 32'd0);
    chk("idle_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("idle_start", 32'(ap_start), 32'd0);

    // timeout: ap_ready never asserted
    do_reset();
    enable = 1'b1;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (ap_start) cyc++;
      else if (cyc > 0) break;
    end
    chk("to_cycles", 32'(cyc), 32'd256);
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_start", 32'(ap_start), 32'd0);
    chk("to_finish", 32'(finish), 32'd1);
    chk("to_state", 32'(state_dbg), 32'(ST_DONE));
    chk("to_pass", 32'(pass_count), 32'd0);
    chk("to_fail", 32'(fail_count), 32'd0);

    // reset asserted during WAIT_DONE
    do_reset();
    enable = 1'b1;
    serve_txn(1, 1, 1'b0, 1'b0);
    wait_start();
    ap_ready = 1'b1;
    @(negedge clock);
    ap_ready = 1'b0;
    chk("mid_state_wait", 32'(state_dbg), 32'(ST_WAIT_DONE));
    #2 reset = 1'b0;
    #1;
    chk("mid_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("mid_start", 32'(ap_start), 32'd0);
    chk("mid_finish", 32'(finish), 32'd0);
    chk("mid_pass", 32'(pass_count), 32'd0);
    chk("mid_fail", 32'(fail_count), 32'd0);
    chk("mid_op_a", 32'(op_a), 32'hAC);
    chk("mid_op_b", 32'(op_b), 32'hE1);
    @(negedge clock);
    reset      = 1'b1;
    model_lfsr = 16'hACE1;
    exp_pass   = 0;
    exp_fail   = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) serve_txn(2, 2, 1'b0, 1'b0);
    wait_finish();
    chk("rerun_pass", 32'(pass_count), 32'd4);
    chk("rerun_fail", 32'(fail_count), 32'd0);

    chk("z_no_start", 32'(z_started), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
